// File: rtl/sma_pkg.sv
// Shared definitions for the SMA feed arbiter: channel count, default word
// width and the arbiter FSM state encoding.
package sma_pkg;

  localparam int DATA_W    = 16;
  localparam int NUM_FEEDS = 4;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

endpackage

// File: rtl/sma_feed_arbiter_rr_pick4.sv
// Combinational 4-way round-robin picker: the first requester found searching
// upward from (ptr + 1) mod 4 wins.
module rr_pick4 (
  input  logic [3:0] i_req,
  input  logic [1:0] i_ptr,
  output logic [1:0] o_winner,
  output logic       o_any
);

  logic [1:0] w_idx;

  // NOTE: every variable driven here gets a default before any branch, so no
  // path leaves a value held over and no latch is inferred.
  always_comb begin
    o_winner = '0;
    o_any    = |i_req;
    w_idx    = '0;
    // Walk from the farthest candidate to the nearest so the nearest requester
    // is the last assignment and therefore the one that sticks.
    for (int k = 3; k >= 0; k--) begin
      w_idx = i_ptr + 2'(k + 1);
      if (i_req[w_idx]) o_winner = w_idx;
    end
  end

endmodule

// File: rtl/sma_feed_arbiter.sv
// Round-robin arbiter sharing one SMA accumulator input among four feeds; a
// grant covers a whole burst, ending on last or on the beat limit.
module sma_feed_arbiter
  import sma_pkg::*;
#(
  parameter int DATA_W    = sma_pkg::DATA_W,
  parameter int MAX_BEATS = 8,
  parameter int CNT_W     = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [NUM_FEEDS-1:0]          in_valid,
  input  logic [NUM_FEEDS-1:0]          in_last,
  input  logic [NUM_FEEDS*DATA_W-1:0]   in_data,
  output logic [NUM_FEEDS-1:0]          in_ready,
  output logic                          out_valid,
  output logic                          out_last,
  output logic [DATA_W-1:0]             out_data,
  input  logic                          out_ready,
  output logic [1:0]                    select,
  output logic                          busy,
  output logic [CNT_W-1:0]              beat_cnt
);

  arb_state_t       r_state,    w_state_nxt;
  logic [1:0]       r_select,   w_select_nxt;
  logic [1:0]       r_rr_ptr,   w_rr_ptr_nxt;
  logic [CNT_W-1:0] r_beat_cnt, w_beat_cnt_nxt;

  logic [1:0] w_winner;
  logic       w_any;
  logic       w_busy;
  logic       w_at_limit;
  logic       w_beat;
  logic       w_release;

  rr_pick4 u_pick (
    .i_req    (in_valid),
    .i_ptr    (r_rr_ptr),
    .o_winner (w_winner),
    .o_any    (w_any)
  );

  // Everything toward the core and the feeds decodes registered state only,
  // so a new request can never be forwarded in the cycle it first appears.
  assign w_busy     = (r_state == BUSY);
  assign w_at_limit = (r_beat_cnt == CNT_W'(MAX_BEATS - 1));
  assign out_data   = in_data[r_select*DATA_W +: DATA_W];
  assign out_valid  = w_busy && in_valid[r_select];
  assign out_last   = w_busy && (in_last[r_select] || w_at_limit);
  assign in_ready   = w_busy ? (NUM_FEEDS'(out_ready) << r_select) : '0;
  assign w_beat     = out_valid && out_ready;
  assign w_release  = w_beat && (in_last[r_select] || w_at_limit);

  assign select   = r_select;
  assign busy     = w_busy;
  assign beat_cnt = r_beat_cnt;

  always_comb begin
    w_state_nxt    = r_state;
    w_select_nxt   = r_select;
    w_rr_ptr_nxt   = r_rr_ptr;
    w_beat_cnt_nxt = r_beat_cnt;
    unique case (r_state)
      IDLE: begin
        if (w_any) begin
          w_state_nxt    = BUSY;
          w_select_nxt   = w_winner;
          w_beat_cnt_nxt = '0;
        end
      end
      BUSY: begin
        if (w_release) begin
          // select is left alone so it still names the channel just served.
          w_state_nxt    = IDLE;
          w_rr_ptr_nxt   = r_select;
          w_beat_cnt_nxt = '0;
        end else if (w_beat) begin
          w_beat_cnt_nxt = r_beat_cnt + 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_select   <= 2'd0;
      r_rr_ptr   <= 2'd3;
      r_beat_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_select   <= w_select_nxt;
      r_rr_ptr   <= w_rr_ptr_nxt;
      r_beat_cnt <= w_beat_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_sma_feed_arbiter.sv
// Self-checking bench for sma_feed_arbiter: directed bursts with literal
// expectations, then randomized traffic against a burst-level reference model.
module tb_sma_feed_arbiter;

  localparam int DATA_W    = 16;
  localparam int MAX_BEATS = 8;
  localparam int CNT_W     = 4;

  logic                clk = 1'b0;
  logic                reset_n;
  logic [3:0]          in_valid;
  logic [3:0]          in_last;
  logic [4*DATA_W-1:0] in_data;
  logic [3:0]          in_ready;
  logic                out_valid;
  logic                out_last;
  logic [DATA_W-1:0]   out_data;
  logic                out_ready;
  logic [1:0]          select;
  logic                busy;
  logic [CNT_W-1:0]    beat_cnt;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: who owns the core, how many words it has delivered in
  // this grant, and who was served last (round-robin origin).
  bit m_granted;
  int m_owner;
  int m_words;
  int m_last_served;

  sma_feed_arbiter #(
    .DATA_W    (DATA_W),
    .MAX_BEATS (MAX_BEATS),
    .CNT_W     (CNT_W)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_last  (out_last),
    .out_data  (out_data),
    .out_ready (out_ready),
    .select    (select),
    .busy      (busy),
    .beat_cnt  (beat_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_granted     = 1'b0;
    m_owner       = 0;
    m_words       = 0;
    m_last_served = 3;
  endtask

  function automatic logic [DATA_W-1:0] word_of(input int ch);
    logic [4*DATA_W-1:0] d;
    d = in_data;
    return d[ch*DATA_W +: DATA_W];
  endfunction

  // Compare every DUT output against the model for the current inputs, then
  // advance the model by what the coming clock edge must do.
  task automatic compare_and_step();
    logic [3:0] e_ready;
    bit e_valid, e_last, accepted;
    e_valid = m_granted && in_valid[m_owner];
    e_last  = m_granted && (in_last[m_owner] || (m_words == MAX_BEATS - 1));
    e_ready = 4'b0;
    if (m_granted && out_ready) e_ready[m_owner] = 1'b1;
    check("busy",      32'(busy),      32'(m_granted));
    check("select",    32'(select),    32'(m_owner));
    check("beat_cnt",  32'(beat_cnt),  32'(m_words));
    check("out_valid", 32'(out_valid), 32'(e_valid));
    check("out_last",  32'(out_last),  32'(e_last));
    check("in_ready",  32'(in_ready),  32'(e_ready));
    if (e_valid) check("out_data", 32'(out_data), 32'(word_of(m_owner)));

    if (!m_granted) begin
      for (int off = 1; off <= 4; off++) begin
        if (!m_granted && in_valid[(m_last_served + off) % 4]) begin
          m_granted = 1'b1;
          m_owner   = (m_last_served + off) % 4;
          m_words   = 0;
        end
      end
    end else begin
      accepted = e_valid && out_ready;
      if (accepted) begin
        m_words++;
        if (in_last[m_owner] || m_words == MAX_BEATS) begin
          m_granted     = 1'b0;
          m_last_served = m_owner;
          m_words       = 0;
        end
      end
    end
  endtask

  // Inputs are driven just after a falling edge; outputs settle for 1 time
  // unit, are compared, then the rising edge is taken.
  task automatic tick();
    #1;
    compare_and_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_word(input int ch, input logic [DATA_W-1:0] w);
    in_data[ch*DATA_W +: DATA_W] = w;
  endtask

  initial begin
    logic [1:0] exp_sel [5];
    logic [3:0] ready_seq;
    logic [3:0] cnt_seq [4];
    exp_sel = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    ready_seq = 4'b1001;  // bit k is out_ready for step k: 1,0,0,1
    cnt_seq = '{4'd0, 4'd1, 4'd1, 4'd1};

    reset_n   = 1'b0;
    in_valid  = '0;
    in_last   = '0;
    in_data   = '0;
    out_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check("reset_busy",     32'(busy),      32'd0);
    check("reset_select",   32'(select),    32'd0);
    check("reset_beat_cnt", 32'(beat_cnt),  32'd0);
    check("reset_in_ready", 32'(in_ready),  32'd0);
    check("reset_out_valid",32'(out_valid), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // All four feeds request single-word bursts: strict 0,1,2,3,0 rotation
    // with one idle cycle between grants.
    in_valid  = 4'b1111;
    in_last   = 4'b1111;
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) set_word(c, 16'h1000 + 16'(c));
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i % 2 == 0) begin
        check("rot_select", 32'(select), 32'(exp_sel[i/2]));
        check("rot_busy",   32'(busy),   32'd1);
      end else begin
        check("rot_gap", 32'(busy), 32'd0);
      end
    end
    in_valid = '0;
    in_last  = '0;
    tick();

    // Channel 2, five-word burst ending on last.
    in_valid = 4'b0100;
    tick();
    for (int b = 0; b < 5; b++) begin
      in_last[2] = (b == 4);
      set_word(2, 16'h2000 + 16'(b));
      #1;
      check("ch2_in_ready", 32'(in_ready), 32'h4);
      check("ch2_beat_cnt", 32'(beat_cnt), 32'(b));
      check("ch2_out_last", 32'(out_last), 32'(b == 4));
      tick();
    end
    check("ch2_released", 32'(busy), 32'd0);
    in_valid = '0;
    in_last  = '0;
    tick();

    // Channel 1 streams without last: forced release at the beat limit, then
    // regranted after a single idle cycle.
    in_valid = 4'b0010;
    tick();
    for (int b = 0; b < MAX_BEATS; b++) begin
      set_word(1, 16'h3000 + 16'(b));
      #1;
      check("ch1_limit_last", 32'(out_last), 32'(b == MAX_BEATS - 1));
      tick();
    end
    check("ch1_forced_release", 32'(busy), 32'd0);
    tick();
    check("ch1_regrant_busy",   32'(busy),   32'd1);
    check("ch1_regrant_select", 32'(select), 32'd1);
    for (int b = 0; b < 4; b++) begin
      set_word(1, 16'h3100 + 16'(b));
      #1;
      check("ch1_tail_cnt", 32'(beat_cnt), 32'(b));
      tick();
    end
    in_last[1] = 1'b1;
    tick();
    in_valid = '0;
    in_last  = '0;
    tick();

    // Channel 3 under back-pressure: word stays put, count moves on ready only.
    in_valid = 4'b1000;
    set_word(3, 16'h00A5);
    tick();
    for (int k = 0; k < 4; k++) begin
      out_ready = ready_seq[k];
      #1;
      check("bp_out_data", 32'(out_data),    32'h00A5);
      check("bp_in_ready", 32'(in_ready[3]), 32'(ready_seq[k]));
      check("bp_beat_cnt", 32'(beat_cnt),    32'(cnt_seq[k]));
      tick();
    end
    check("bp_cnt_after", 32'(beat_cnt), 32'd2);
    out_ready  = 1'b1;
    in_last[3] = 1'b1;
    tick();
    in_valid = '0;
    in_last  = '0;
    tick();

    // Channel 0 goes quiet mid-burst while channel 1 asks: grant is held.
    in_valid = 4'b0001;
    set_word(0, 16'h4000);
    tick();
    tick();
    in_valid = 4'b0010;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("hold_select",    32'(select),    32'd0);
      check("hold_out_valid", 32'(out_valid), 32'd0);
      check("hold_beat_cnt",  32'(beat_cnt),  32'd1);
      tick();
    end
    in_valid = 4'b0001;
    in_last  = 4'b0001;
    tick();
    in_valid = '0;
    in_last  = '0;
    tick();

    // Reset mid-burst on channel 2 after three beats.
    in_valid = 4'b0100;
    tick();
    for (int b = 0; b < 3; b++) tick();
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_busy",     32'(busy),      32'd0);
    check("arst_select",   32'(select),    32'd0);
    check("arst_beat_cnt", 32'(beat_cnt),  32'd0);
    check("arst_out_last", 32'(out_last),  32'd0);
    check("arst_in_ready", 32'(in_ready),  32'd0);
    model_reset();
    @(negedge clk);
    reset_n  = 1'b1;
    in_valid = 4'b0101;
    tick();
    check("arst_ch0_wins", 32'(select), 32'd0);
    check("arst_ch0_busy", 32'(busy),   32'd1);

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      in_valid  = 4'($urandom_range(0, 15));
      in_last   = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0;
      out_ready = ($urandom_range(0, 3) != 0);
      for (int c = 0; c < 4; c++) set_word(c, 16'($urandom));
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
